// File: rtl/pic_host_pkg.sv
// Shared types for the PIC host controller: FSM states, write-list indices,
// latched configuration payload and write-sequencing helpers.
package pic_host_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_GAP,
    ST_ACK1,
    ST_ACK_GAP,
    ST_ACK2,
    ST_ACK_DONE
  } state_e;

  typedef enum logic [2:0] {
    WI_ICW1,
    WI_ICW2,
    WI_ICW3,
    WI_ICW4,
    WI_OCW1
  } wr_idx_e;

  typedef struct packed {
    logic [BYTE_W-1:0] icw1;
    logic [BYTE_W-1:0] icw2;
    logic [BYTE_W-1:0] icw3;
    logic [BYTE_W-1:0] icw4;
    logic [BYTE_W-1:0] ocw1;
  } cfg_t;

  // ICW3 only exists in cascade mode (SNGL=0), ICW4 only when IC4=1.
  function automatic wr_idx_e next_wr_idx(wr_idx_e idx, logic sngl, logic ic4);
    wr_idx_e nxt;
    case (idx)
      WI_ICW1: nxt = WI_ICW2;
      WI_ICW2: nxt = !sngl ? WI_ICW3 : (ic4 ? WI_ICW4 : WI_OCW1);
      WI_ICW3: nxt = ic4 ? WI_ICW4 : WI_OCW1;
      default: nxt = WI_OCW1;
    endcase
    return nxt;
  endfunction

  function automatic logic [BYTE_W-1:0] wr_byte(wr_idx_e idx, cfg_t cfg);
    logic [BYTE_W-1:0] b;
    case (idx)
      WI_ICW1: b = cfg.icw1;
      WI_ICW2: b = cfg.icw2;
      WI_ICW3: b = cfg.icw3;
      WI_ICW4: b = cfg.icw4;
      default: b = cfg.ocw1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pic_host_controller_if.sv
// PIC-side bus of the host controller: strobes, address bit and data bus.
interface pic_host_controller_if;
  import pic_host_pkg::*;

  logic              cs_n;
  logic              wr_n;
  logic              rd_n;
  logic              inta_n;
  logic              a0;
  logic              pic_int;
  logic              pic_data_oe;
  logic [BYTE_W-1:0] pic_data_in;
  logic [BYTE_W-1:0] pic_data_out;

  modport master (
    output cs_n, wr_n, rd_n, inta_n, a0, pic_data_out, pic_data_oe,
    input  pic_int, pic_data_in
  );

  modport slave (
    input  cs_n, wr_n, rd_n, inta_n, a0, pic_data_out, pic_data_oe,
    output pic_int, pic_data_in
  );
endinterface

// File: rtl/strobe_timer.sv
// Shared strobe-width / gap down-counter: loads N-1 and counts to zero.
module strobe_timer
  import pic_host_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c,
  output logic             busy_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_c = (cnt_q == '0);
  assign busy_c = (cnt_q != '0);

endmodule

// File: rtl/pic_host_controller.sv
// Host-side 8259-style PIC controller: programs ICW/OCW bytes after start_cfg
// and runs two-pulse interrupt acknowledge cycles to capture the vector.
module pic_host_controller
  import pic_host_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_cfg,
  input  logic [BYTE_W-1:0]     icw1,
  input  logic [BYTE_W-1:0]     icw2,
  input  logic [BYTE_W-1:0]     icw3,
  input  logic [BYTE_W-1:0]     icw4,
  input  logic [BYTE_W-1:0]     ocw1,
  input  logic                  ack_enable,
  pic_host_controller_if.master pic,
  output logic                  cfg_done,
  output logic                  busy,
  output logic [BYTE_W-1:0]     vector,
  output logic                  vector_valid
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q;
  wr_idx_e           idx_q;
  wr_idx_e           nxt_idx_c;
  cfg_t              cfg_q;
  cfg_t              cfg_in_c;
  logic              cs_n_q;
  logic              wr_n_q;
  logic              inta_n_q;
  logic              a0_q;
  logic              oe_q;
  logic [BYTE_W-1:0] data_q;
  logic              ack_go_c;
  logic              tmr_load_c;
  logic [CNT_W-1:0]  tmr_val_c;
  logic              tmr_done_c;
  logic              tmr_busy_c;

  assign cfg_in_c  = {icw1, icw2, icw3, icw4, ocw1};
  assign nxt_idx_c = next_wr_idx(idx_q, cfg_q.icw1[1], cfg_q.icw1[0]);
  assign ack_go_c  = cfg_done && ack_enable && pic.pic_int;

  assign pic.cs_n         = cs_n_q;
  assign pic.wr_n         = wr_n_q;
  assign pic.rd_n         = 1'b1;
  assign pic.inta_n       = inta_n_q;
  assign pic.a0           = a0_q;
  assign pic.pic_data_oe  = oe_q;
  assign pic.pic_data_out = data_q;

  // Timer is reloaded on every edge that enters a timed state.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!start_cfg && ack_go_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = PULSE_LD;
        end
      end
      ST_WR_SETUP: begin
        tmr_load_c = 1'b1;
        tmr_val_c  = PULSE_LD;
      end
      ST_WR_STROBE, ST_ACK1: begin
        tmr_load_c = tmr_done_c;
        tmr_val_c  = GAP_LD;
      end
      ST_ACK_GAP: begin
        tmr_load_c = tmr_done_c;
        tmr_val_c  = PULSE_LD;
      end
      default: begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
      end
    endcase
  end

  strobe_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c),
    .busy_c   (tmr_busy_c)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= WI_ICW1;
      cfg_q        <= '0;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      inta_n_q     <= 1'b1;
      a0_q         <= 1'b0;
      oe_q         <= 1'b0;
      data_q       <= '0;
      cfg_done     <= 1'b0;
      busy         <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
    end else begin
      vector_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_cfg) begin
            cfg_q    <= cfg_in_c;
            idx_q    <= WI_ICW1;
            cfg_done <= 1'b0;
            busy     <= 1'b1;
            state_q  <= ST_WR_SETUP;
            cs_n_q   <= 1'b0;
            a0_q     <= 1'b0;
            data_q   <= cfg_in_c.icw1;
            oe_q     <= 1'b1;
          end else if (ack_go_c) begin
            busy     <= 1'b1;
            state_q  <= ST_ACK1;
            inta_n_q <= 1'b0;
          end
        end
        ST_WR_SETUP: begin
          state_q <= ST_WR_STROBE;
          wr_n_q  <= 1'b0;
        end
        ST_WR_STROBE: begin
          if (!tmr_busy_c) begin
            state_q <= ST_WR_GAP;
            wr_n_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
          end
        end
        ST_WR_GAP: begin
          if (!tmr_busy_c) begin
            if (idx_q == WI_OCW1) begin
              state_q  <= ST_IDLE;
              busy     <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              idx_q   <= nxt_idx_c;
              state_q <= ST_WR_SETUP;
              cs_n_q  <= 1'b0;
              a0_q    <= 1'b1;
              data_q  <= wr_byte(nxt_idx_c, cfg_q);
              oe_q    <= 1'b1;
            end
          end
        end
        ST_ACK1: begin
          if (!tmr_busy_c) begin
            state_q  <= ST_ACK_GAP;
            inta_n_q <= 1'b1;
          end
        end
        ST_ACK_GAP: begin
          if (!tmr_busy_c) begin
            state_q  <= ST_ACK2;
            inta_n_q <= 1'b0;
          end
        end
        ST_ACK2: begin
          if (!tmr_busy_c) begin
            state_q      <= ST_ACK_DONE;
            inta_n_q     <= 1'b1;
            vector       <= pic.pic_data_in;
            vector_valid <= 1'b1;
          end
        end
        ST_ACK_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_controller.sv
// Directed self-checking bench for pic_host_controller (PULSE=2, GAP=1).
module tb_pic_host_controller;

  localparam int PULSE = 2;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_cfg;
  logic       ack_enable;
  logic [7:0] icw1, icw2, icw3, icw4, ocw1;
  logic       cfg_done, busy, vector_valid;
  logic [7:0] vector;

  pic_host_controller_if pic_bus();

  pic_host_controller #(.PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_cfg    (start_cfg),
    .icw1         (icw1),
    .icw2         (icw2),
    .icw3         (icw3),
    .icw4         (icw4),
    .ocw1         (ocw1),
    .ack_enable   (ack_enable),
    .pic          (pic_bus.master),
    .cfg_done     (cfg_done),
    .busy         (busy),
    .vector       (vector),
    .vector_valid (vector_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus activity observed at each falling edge.
  logic [8:0] wr_rec[$];
  int         wr_w[$];
  int         wr_run, wr_glitch;
  int         inta_w[$];
  int         inta_gap[$];
  int         inta_run, inta_hi;
  int         vv_cnt, ack_bad, rd_bad;
  logic [7:0] vv_vec;
  logic [7:0] ack_byte;

  task automatic clear_logs();
    wr_rec.delete(); wr_w.delete(); inta_w.delete(); inta_gap.delete();
    wr_run = 0; wr_glitch = 0; inta_run = 0; inta_hi = 0;
    vv_cnt = 0; ack_bad = 0; rd_bad = 0; vv_vec = 8'h00;
  endtask

  task automatic tick();
    @(negedge clk);
    if (pic_bus.rd_n !== 1'b1) rd_bad++;
    if (pic_bus.wr_n === 1'b0) begin
      if (wr_run == 0) wr_rec.push_back({pic_bus.a0, pic_bus.pic_data_out});
      else if ({pic_bus.a0, pic_bus.pic_data_out} !== wr_rec[$]) wr_glitch++;
      if (pic_bus.cs_n !== 1'b0 || pic_bus.pic_data_oe !== 1'b1) wr_glitch++;
      wr_run++;
    end else if (wr_run != 0) begin
      wr_w.push_back(wr_run);
      wr_run = 0;
    end
    if (pic_bus.inta_n === 1'b0) begin
      if (inta_run == 0 && inta_w.size() > 0) inta_gap.push_back(inta_hi);
      inta_run++;
      inta_hi = 0;
      if (pic_bus.cs_n !== 1'b1 || pic_bus.wr_n !== 1'b1 || pic_bus.pic_data_oe !== 1'b0)
        ack_bad++;
    end else begin
      if (inta_run != 0) begin
        inta_w.push_back(inta_run);
        inta_run = 0;
      end
      inta_hi++;
    end
    if (vector_valid === 1'b1) begin
      vv_cnt++;
      vv_vec = vector;
    end
    // Vector byte only present in the last cycle of each second INTA pulse.
    if (pic_bus.inta_n === 1'b0 && inta_run == PULSE && (inta_w.size() % 2) == 1)
      pic_bus.pic_data_in = ack_byte;
    else
      pic_bus.pic_data_in = 8'hEE;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({pic_bus.cs_n, pic_bus.wr_n, pic_bus.rd_n, pic_bus.inta_n, pic_bus.a0,
         pic_bus.pic_data_oe, cfg_done, busy, vector_valid} !== 9'b111100000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=%b", {pic_bus.cs_n, pic_bus.wr_n, pic_bus.rd_n,
               pic_bus.inta_n, pic_bus.a0, pic_bus.pic_data_oe, cfg_done, busy, vector_valid},
               9'b111100000);
    end
    checks++;
    if ({pic_bus.pic_data_out, vector} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0000", {pic_bus.pic_data_out, vector});
    end
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({pic_bus.cs_n, pic_bus.wr_n, pic_bus.inta_n, cfg_done, busy} !== 5'b11100) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=11100",
               {pic_bus.cs_n, pic_bus.wr_n, pic_bus.inta_n, cfg_done, busy});
    end
  endtask

  task automatic test_no_ack(input string name, input logic en);
    clear_logs();
    ack_enable = en;
    pic_bus.pic_int = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    pic_bus.pic_int = 1'b0;
    checks++;
    if (inta_w.size() + inta_run != 0) begin
      errors++;
      $display("FAIL %s inta_pulses got=%0d exp=0", name, inta_w.size() + inta_run);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy got=%b exp=0", name, busy);
    end
  endtask

  task automatic test_cfg(input string name, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                          input int exp_n, input bit poke_start);
    logic [8:0] exp[$];
    int t;
    int bad_w;
    bit done;
    exp.push_back({1'b0, b1});
    exp.push_back({1'b1, b2});
    if (!b1[1]) exp.push_back({1'b1, b3});
    if (b1[0]) exp.push_back({1'b1, b4});
    exp.push_back({1'b1, b5});
    clear_logs();
    pic_bus.pic_int = 1'b0;
    {icw1, icw2, icw3, icw4, ocw1} = {b1, b2, b3, b4, b5};
    start_cfg = 1'b1;
    tick();
    start_cfg = 1'b0;
    {icw1, icw2, icw3, icw4, ocw1} = ~{b1, b2, b3, b4, b5};
    checks++;
    if ({pic_bus.cs_n, pic_bus.wr_n, pic_bus.pic_data_oe, busy, cfg_done} !== 5'b01110) begin
      errors++;
      $display("FAIL %s setup got=%b exp=01110", name,
               {pic_bus.cs_n, pic_bus.wr_n, pic_bus.pic_data_oe, busy, cfg_done});
    end
    t = 1;
    done = 1'b0;
    while (!done && t < 200) begin
      if (poke_start && t == 6) start_cfg = 1'b1;
      tick();
      start_cfg = 1'b0;
      t++;
      if (cfg_done === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout cycles=%0d limit=200", name, t);
    end
    checks++;
    if (t != 4 * exp_n + 1) begin
      errors++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, t, 4 * exp_n + 1);
    end
    checks++;
    if (wr_rec.size() != exp_n) begin
      errors++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, wr_rec.size(), exp_n);
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= wr_rec.size() || wr_rec[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s write%0d {a0,data} got=%h exp=%h", name, i,
                 (i < wr_rec.size()) ? wr_rec[i] : 9'h1FF, exp[i]);
      end
    end
    bad_w = 0;
    foreach (wr_w[i]) if (wr_w[i] != PULSE) bad_w++;
    checks++;
    if (bad_w != 0 || wr_glitch != 0 || rd_bad != 0) begin
      errors++;
      $display("FAIL %s strobe bad_width=%0d unstable=%0d rd_active=%0d exp=0/0/0",
               name, bad_w, wr_glitch, rd_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done got=%b exp=0", name, busy);
    end
  endtask

  task automatic test_ack();
    int t;
    int bad_w;
    clear_logs();
    ack_enable = 1'b1;
    ack_byte = 8'h48;
    pic_bus.pic_int = 1'b1;
    t = 0;
    while (vv_cnt == 0 && t < 50) begin
      tick();
      t++;
      if (inta_run > 0) pic_bus.pic_int = 1'b0;
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (t != 6) begin
      errors++;
      $display("FAIL ack_latency got=%0d exp=6", t);
    end
    checks++;
    if (vv_vec !== 8'h48 || vector !== 8'h48) begin
      errors++;
      $display("FAIL ack_vector got=%h/%h exp=48", vv_vec, vector);
    end
    checks++;
    if (vv_cnt != 1) begin
      errors++;
      $display("FAIL ack_valid_pulses got=%0d exp=1", vv_cnt);
    end
    bad_w = 0;
    foreach (inta_w[i]) if (inta_w[i] != PULSE) bad_w++;
    checks++;
    if (inta_w.size() != 2 || bad_w != 0) begin
      errors++;
      $display("FAIL ack_inta pulses=%0d bad_width=%0d exp=2/0", inta_w.size(), bad_w);
    end
    checks++;
    if (inta_gap.size() != 1 || inta_gap[0] != GAP) begin
      errors++;
      $display("FAIL ack_gap count=%0d first=%0d exp=1/%0d", inta_gap.size(),
               (inta_gap.size() > 0) ? inta_gap[0] : -1, GAP);
    end
    checks++;
    if (ack_bad != 0 || wr_rec.size() != 0 || rd_bad != 0) begin
      errors++;
      $display("FAIL ack_bus bus_active=%0d writes=%0d rd_active=%0d exp=0/0/0",
               ack_bad, wr_rec.size(), rd_bad);
    end
  endtask

  task automatic test_start_during_ack();
    int t;
    clear_logs();
    ack_enable = 1'b1;
    ack_byte = 8'h5A;
    pic_bus.pic_int = 1'b1;
    t = 0;
    while (inta_run == 0 && t < 10) begin
      tick();
      t++;
    end
    {icw1, icw2, icw3, icw4, ocw1} = 40'h12_08_02_01_00;
    start_cfg = 1'b1;
    tick();
    start_cfg = 1'b0;
    pic_bus.pic_int = 1'b0;
    t = 0;
    while (vv_cnt == 0 && t < 50) begin
      tick();
      t++;
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (vv_vec !== 8'h5A || vv_cnt != 1) begin
      errors++;
      $display("FAIL start_in_ack vector got=%h/%0d exp=5a/1", vv_vec, vv_cnt);
    end
    checks++;
    if (wr_rec.size() != 0 || inta_w.size() != 2) begin
      errors++;
      $display("FAIL start_in_ack activity writes=%0d inta=%0d exp=0/2",
               wr_rec.size(), inta_w.size());
    end
    checks++;
    if ({cfg_done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL start_in_ack status got=%b exp=10", {cfg_done, busy});
    end
  endtask

  task automatic test_back_to_back();
    int t;
    clear_logs();
    ack_enable = 1'b1;
    ack_byte = 8'hA3;
    pic_bus.pic_int = 1'b1;
    t = 0;
    while (vv_cnt < 2 && t < 60) begin
      tick();
      t++;
    end
    pic_bus.pic_int = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (t != 13) begin
      errors++;
      $display("FAIL b2b_latency got=%0d exp=13", t);
    end
    checks++;
    if (inta_w.size() != 4 || vv_cnt != 2 || vv_vec !== 8'hA3) begin
      errors++;
      $display("FAIL b2b_count inta=%0d valid=%0d vec=%h exp=4/2/a3",
               inta_w.size(), vv_cnt, vv_vec);
    end
    checks++;
    if (inta_gap.size() != 3 || inta_gap[0] != 1 || inta_gap[1] != 2 || inta_gap[2] != 1) begin
      errors++;
      $display("FAIL b2b_gaps count=%0d exp=3 with gaps 1,2,1", inta_gap.size());
    end
  endtask

  task automatic test_reset_mid_strobe();
    int t;
    clear_logs();
    ack_enable = 1'b0;
    pic_bus.pic_int = 1'b0;
    {icw1, icw2, icw3, icw4, ocw1} = 40'h13_20_04_01_FB;
    start_cfg = 1'b1;
    tick();
    start_cfg = 1'b0;
    t = 0;
    while (!(wr_rec.size() == 2 && wr_run == 2) && t < 40) begin
      tick();
      t++;
    end
    checks++;
    if (pic_bus.wr_n !== 1'b0 || pic_bus.a0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid reach_strobe wr_n=%b a0=%b exp=0/1", pic_bus.wr_n, pic_bus.a0);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pic_bus.wr_n, pic_bus.cs_n, pic_bus.inta_n, pic_bus.pic_data_oe, pic_bus.a0,
         cfg_done, busy} !== 7'b1110000) begin
      errors++;
      $display("FAIL rst_mid release got=%b exp=1110000", {pic_bus.wr_n, pic_bus.cs_n,
               pic_bus.inta_n, pic_bus.pic_data_oe, pic_bus.a0, cfg_done, busy});
    end
    checks++;
    if (pic_bus.pic_data_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid data got=%h exp=00", pic_bus.pic_data_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (wr_rec.size() != 0 || {cfg_done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid no_restart writes=%0d status=%b exp=0/00",
               wr_rec.size(), {cfg_done, busy});
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_cfg = 1'b0;
    ack_enable = 1'b0;
    {icw1, icw2, icw3, icw4, ocw1} = '0;
    pic_bus.pic_int = 1'b0;
    pic_bus.pic_data_in = 8'h00;
    ack_byte = 8'h00;
    clear_logs();

    test_reset();
    test_no_ack("pre_cfg", 1'b1);
    test_cfg("cfg_13", 8'h13, 8'h20, 8'h04, 8'h01, 8'hFB, 4, 1'b0);
    test_ack();
    test_no_ack("ack_disabled", 1'b0);
    test_cfg("cfg_11_busy_start", 8'h11, 8'h70, 8'h04, 8'h03, 8'h5A, 5, 1'b1);
    test_cfg("cfg_12", 8'h12, 8'h08, 8'h02, 8'h01, 8'h00, 3, 1'b0);
    test_start_during_ack();
    test_back_to_back();
    test_reset_mid_strobe();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic_host_controller.md
PIC_HOST_CONTROLLER -- requirements
Module: pic_host_controller

Interface
REQ-001 Parameter PULSE_CYCLES, default 2: clock cycles each active-low strobe (wr_n, rd_n, inta_n) is held low; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles between consecutive strobes; legal range 1..15.
REQ-003 Ports: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Ports: start_cfg  in  1  one-cycle pulse that starts the programming sequence.
REQ-006 Ports: icw1, icw2, icw3, icw4, ocw1  in  8 each  configuration bytes, sampled on the start_cfg cycle.
REQ-007 Ports: ack_enable  in  1  allows interrupt acknowledge cycles.
REQ-008 Ports: pic_int  in  1  INT from the PIC, active high.
REQ-009 Ports: pic_data_in  in  8  PIC data bus as seen by the host.
REQ-010 Ports: pic_data_out  out  8  byte driven toward the PIC; pic_data_oe  out  1  host drives the bus when high.
REQ-011 Ports: cs_n, wr_n, rd_n, inta_n  out  1 each  active-low PIC bus strobes; a0  out  1  PIC address bit.
REQ-012 Ports: cfg_done  out  1  high once programming has completed; busy  out  1  FSM not in IDLE.
REQ-013 Ports: vector  out  8  captured interrupt vector; vector_valid  out  1  one-cycle pulse when vector updates.

Function
REQ-014 FSM states: IDLE, WR_SETUP, WR_STROBE, WR_GAP, ACK1, ACK_GAP, ACK2, ACK_DONE.
REQ-015 In IDLE, start_cfg SHALL latch the five config bytes, clear cfg_done, and go to WR_SETUP; start_cfg has priority over pic_int.
REQ-016 Write list: ICW1 with a0=0, then ICW2 with a0=1, then ICW3 with a0=1 only if icw1[1]=0, then ICW4 with a0=1 only if icw1[0]=1, then OCW1 with a0=1.
REQ-017 WR_SETUP lasts 1 cycle: cs_n=0, a0 valid, pic_data_oe=1, data valid, wr_n=1.
REQ-018 WR_STROBE holds wr_n=0 for PULSE_CYCLES cycles; data, a0 and cs_n remain stable.
REQ-019 WR_GAP deasserts wr_n, cs_n and pic_data_oe for GAP_CYCLES cycles, then goes to the next write, or to IDLE after OCW1.
REQ-020 cfg_done SHALL rise on the cycle the FSM returns to IDLE after OCW1.
REQ-021 In IDLE with cfg_done=1, ack_enable=1 and pic_int=1 (sampled), the FSM SHALL enter ACK1; otherwise pic_int is ignored.
REQ-022 ACK1 holds inta_n=0 for PULSE_CYCLES cycles; ACK_GAP holds inta_n=1 for GAP_CYCLES cycles.
REQ-023 ACK2 holds inta_n=0 for PULSE_CYCLES cycles; pic_data_in is registered into vector on the last ACK2 cycle.
REQ-024 ACK_DONE lasts 1 cycle, pulses vector_valid, then returns to IDLE; a still-high pic_int starts a new acknowledge only after that IDLE cycle.
REQ-025 pic_data_oe SHALL be 0 in every ACK state; cs_n, rd_n and wr_n SHALL be 1 during acknowledge.
REQ-026 rd_n SHALL stay 1 at all times; it is reserved for a later status-read extension.
REQ-027 start_cfg while busy is ignored, with no effect on latched bytes or on sequence progress.
REQ-028 Deassertion of pic_int after ACK1 begins SHALL NOT abort the sequence; the captured byte is reported as-is.
REQ-029 Strobe width and gap counters are 4-bit, load PULSE_CYCLES-1 or GAP_CYCLES-1, and count down to 0.

Reset
REQ-030 reset_n low SHALL immediately force IDLE, cs_n=wr_n=rd_n=inta_n=1, a0=0, pic_data_oe=0, pic_data_out=0, vector=0, vector_valid=0, cfg_done=0, busy=0, counters=0.
REQ-031 Reset in any state, including mid-strobe, SHALL release all strobes asynchronously; after release, the PIC is reprogrammed only by a new start_cfg.

Structure
REQ-032 FSM state encoding and write-index constants SHALL live in a shared package, pic_host_pkg.
REQ-033 A single sub-module, strobe_timer, SHALL implement the shared PULSE/GAP down-counter with load, done and busy signals.

Verification
REQ-034 With icw1=0x13 (SNGL=1, IC4=1), pulse start_cfg: expect exactly 4 writes, ICW1(a0=0)=0x13, ICW2=icw2, ICW4=icw4, OCW1=ocw1, each wr_n low 2 cycles, then cfg_done=1.
REQ-035 With icw1=0x11 (cascade, IC4=1): expect 5 writes including ICW3; with icw1=0x12: expect 3 writes, ICW1, ICW2, OCW1.
REQ-036 After config, drive pic_int=1 and pic_data_in=0x48 during ACK2: expect two inta_n pulses separated by 1 high cycle, vector=0x48, one vector_valid pulse.
REQ-037 Drive pic_int=1 before cfg_done, or with ack_enable=0: expect no inta_n activity.
REQ-038 Assert reset_n=0 during the second cycle of a wr_n low pulse: expect wr_n=1 and cs_n=1 in the same cycle, and cfg_done=0.
REQ-039 Pulse start_cfg during an acknowledge: expect it to be ignored and the acknowledge to complete normally.
